dla_hld_lsu_word_span_decoder: RTL and testbench
================================================

DLA_HLD_LSU_WORD_SPAN_DECODER -- requirements
Module: dla_hld_lsu_word_span_decoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-002 Parameter KER_BYTES, default 32: kernel word size in bytes, power of 2.
REQ-003 Parameter MEM_BYTES, default 64: memory word size in bytes, power of 2.
REQ-004 Parameter MAX_MEM_WORDS_PER_KER_WORD, default 2: legal values 1, 2 or 3; caller guarantees no kernel word spans more memory words than this.
REQ-005 Port clock, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port i_valid, input, 1: upstream kernel access valid.
REQ-008 Port i_addr, input, ADDR_WIDTH: kernel word byte address.
REQ-009 Port o_ready, output, 1: upstream transfer accepted when i_valid & o_ready.
REQ-010 Port i_flush, input, 1: single-cycle pulse, end of access stream.
REQ-011 Port o_valid, output, 1: command valid toward the cmd FIFO.
REQ-012 Port i_ready, input, 1: cmd FIFO not full; output transfer when o_valid & i_ready (a "fire").
REQ-013 Port o_word_addr, output, ADDR_WIDTH-log2(MEM_BYTES): memory word address of the first section.
REQ-014 Ports o_spans_two, o_spans_three, o_needs_second_cycle, o_needs_third_cycle, o_can_coalesce, outputs, 1 each: per-command kernel-word descriptors.
REQ-015 Port o_idle, output, 1: no held word and no pending flush.

Function
REQ-016 The block SHALL hold one kernel word (held register) until its successor arrives, so that coalescing can be decided.
- offset = i_addr mod MEM_BYTES.
- first = i_addr >> log2(MEM_BYTES).
- last = (i_addr + KER_BYTES - 1) >> log2(MEM_BYTES), computed with a carry bit and truncated to the o_word_addr width; wrap at the top of the address space is modular.
REQ-017 Span flags, registered with the held word:
- spans_two = (last != first).
- spans_three = (last - first == 2).
- needs_second_cycle = spans_two; needs_third_cycle = spans_three.
- Flags the MAX_MEM_WORDS_PER_KER_WORD setting makes impossible SHALL be tied 0.
REQ-018 o_valid = held_valid & ((i_valid & ~flush_pending) | flush_pending).
REQ-019 o_ready = ~flush_pending & (~held_valid | fire); a fire and a new acceptance in the same cycle replaces the held word with no bubble.
REQ-020 o_can_coalesce = ~flush_pending & (held.last == first(i_addr)); it is 0 on any flush-driven output.
REQ-021 o_word_addr and all flags SHALL be driven from the held register; they stay stable while o_valid & ~i_ready.
REQ-022 i_flush SHALL set flush_pending:
- If held_valid: flush_pending clears on the fire of the held word.
- If ~held_valid: flush_pending clears the next cycle.
- i_flush coincident with an accepted input: that input becomes the held word and is then flushed.
REQ-023 Latency: an accepted input appears at the outputs no earlier than the cycle after its successor is accepted, or one cycle after a flush.
REQ-024 o_idle = ~held_valid & ~flush_pending.

Reset
REQ-025 On reset = 1 at a clock edge: held_valid = 0, flush_pending = 0, timeout counter = 0; any held word is discarded.
REQ-026 During and immediately after reset: o_valid = 0, o_ready = 1, o_idle = 1; data outputs = 0.

Configuration
REQ-027 Macro DLA_HLD_LSU_SPAN_TIMEOUT_FLUSH_EN.
- Defined: an 8-bit counter increments each cycle with held_valid & ~i_valid & ~flush_pending, and resets to 0 otherwise. When it reaches 255 it SHALL set flush_pending exactly as i_flush would.
- Not defined: counter absent; a held word leaves only on a successor or i_flush.

Verification
REQ-028 Coalesce: addr 0x000 then 0x020 (KER_BYTES=32, MEM_BYTES=64) -> one fire with word_addr 0x0, spans_two=0, can_coalesce=1.
REQ-029 Two-span: addr 0x030 then 0x050 -> first command spans_two=1, needs_second_cycle=1, word_addr 0x0, can_coalesce=1 (last=1=first of next).
REQ-030 Three-span: KER_BYTES=128, MAX=3, addr 0x030 then 0x200 -> spans_three=1, needs_third_cycle=1, can_coalesce=0.
REQ-031 Flush: addr 0x040, then i_flush pulse -> next cycle o_valid=1, word_addr 0x1, can_coalesce=0; after the fire, o_idle=1; o_ready=0 while flush_pending.
REQ-032 Backpressure: i_ready=0 for 5 cycles with a word held and a new i_valid -> o_valid=1, outputs stable, o_ready=0; first cycle with i_ready=1 fires and accepts at the same edge.
REQ-033 Reset mid-stream: word held, reset for 1 cycle -> no fire of that word, o_idle=1. Timeout (macro defined): single word, no input -> fire with can_coalesce=0 exactly 256 cycles after acceptance.

Source files
------------

// File: rtl/dla_hld_lsu_word_span_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dla_hld_lsu_word_span_decoder_if : kernel-access in / command out bundle   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface dla_hld_lsu_word_span_decoder_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORD_ADDR_WIDTH = 26
);
  logic                       i_valid;
  logic [ADDR_WIDTH-1:0]      i_addr;
  logic                       o_ready;
  logic                       i_flush;
  logic                       o_valid;
  logic                       i_ready;
  logic [WORD_ADDR_WIDTH-1:0] o_word_addr;
  logic                       o_spans_two;
  logic                       o_spans_three;
  logic                       o_needs_second_cycle;
  logic                       o_needs_third_cycle;
  logic                       o_can_coalesce;
  logic                       o_idle;

  modport master (
    output i_valid, i_addr, i_flush, i_ready,
    input  o_ready, o_valid, o_word_addr, o_spans_two, o_spans_three,
           o_needs_second_cycle, o_needs_third_cycle, o_can_coalesce, o_idle
  );

  modport slave (
    input  i_valid, i_addr, i_flush, i_ready,
    output o_ready, o_valid, o_word_addr, o_spans_two, o_spans_three,
           o_needs_second_cycle, o_needs_third_cycle, o_can_coalesce, o_idle
  );
endinterface
`default_nettype wire

// File: rtl/dla_hld_lsu_word_span_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dla_hld_lsu_word_span_decoder : holds one kernel word, emits span/coalesce |
// | descriptors. Optional idle timeout flush: DLA_HLD_LSU_SPAN_TIMEOUT_FLUSH_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dla_hld_lsu_word_span_decoder #(
  parameter int ADDR_WIDTH                 = 32,
  parameter int KER_BYTES                  = 32,
  parameter int MEM_BYTES                  = 64,
  parameter int MAX_MEM_WORDS_PER_KER_WORD = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  dla_hld_lsu_word_span_decoder_if.slave bus
);
  localparam int C_MEM_LOG2 = $clog2(MEM_BYTES);
  localparam int C_WA       = ADDR_WIDTH - C_MEM_LOG2;
  localparam logic [ADDR_WIDTH:0] C_KER_SPAN = (ADDR_WIDTH+1)'(KER_BYTES - 1);

  logic [C_WA-1:0] w_first, w_last, w_diff;
  logic            w_spans_two, w_spans_three;
  logic            w_o_valid, w_o_ready, w_fire, w_accept, w_timeout;

  logic            held_valid_q, held_valid_d;
  logic [C_WA-1:0] held_addr_q, held_addr_d;
  logic [C_WA-1:0] held_last_q, held_last_d;
  logic            spans_two_q, spans_two_d;
  logic            spans_three_q, spans_three_d;
  logic            flush_pending_q, flush_pending_d;

  // Last word uses a carry bit, then wraps modulo the word-address space.
  always_comb begin
    w_first       = bus.i_addr[ADDR_WIDTH-1:C_MEM_LOG2];
    w_last        = C_WA'(({1'b0, bus.i_addr} + C_KER_SPAN) >> C_MEM_LOG2);
    w_diff        = w_last - w_first;
    w_spans_two   = (MAX_MEM_WORDS_PER_KER_WORD > 1) && (w_diff != '0);
    w_spans_three = (MAX_MEM_WORDS_PER_KER_WORD > 2) && (w_diff == C_WA'(2));
  end

`ifdef DLA_HLD_LSU_SPAN_TIMEOUT_FLUSH_EN
  logic [7:0] timer_q, timer_d;

  always_comb begin
    timer_d   = (held_valid_q & ~bus.i_valid & ~flush_pending_q) ? timer_q + 8'd1 : 8'd0;
    w_timeout = (timer_d == 8'hFF);
  end

  always_ff @(posedge clock) begin
    if (reset) timer_q <= 8'd0;
    else       timer_q <= timer_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_o_valid = held_valid_q & (bus.i_valid | flush_pending_q);
    w_fire    = w_o_valid & bus.i_ready;
    w_o_ready = ~flush_pending_q & (~held_valid_q | w_fire);
    w_accept  = bus.i_valid & w_o_ready;

    held_valid_d    = held_valid_q;
    held_addr_d     = held_addr_q;
    held_last_d     = held_last_q;
    spans_two_d     = spans_two_q;
    spans_three_d   = spans_three_q;
    flush_pending_d = flush_pending_q;

    if (w_accept) begin
      held_valid_d  = 1'b1;
      held_addr_d   = w_first;
      held_last_d   = w_last;
      spans_two_d   = w_spans_two;
      spans_three_d = w_spans_three;
    end else if (w_fire) begin
      held_valid_d  = 1'b0;
    end

    // A pending flush retires with the held word's fire, or at once if nothing is held.
    if (flush_pending_q) begin
      if (~held_valid_q | w_fire) flush_pending_d = 1'b0;
    end else if (bus.i_flush | w_timeout) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      held_valid_q    <= 1'b0;
      held_addr_q     <= '0;
      held_last_q     <= '0;
      spans_two_q     <= 1'b0;
      spans_three_q   <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      held_valid_q    <= held_valid_d;
      held_addr_q     <= held_addr_d;
      held_last_q     <= held_last_d;
      spans_two_q     <= spans_two_d;
      spans_three_q   <= spans_three_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign bus.o_valid              = w_o_valid;
  assign bus.o_ready              = w_o_ready;
  assign bus.o_word_addr          = held_addr_q;
  assign bus.o_spans_two          = spans_two_q;
  assign bus.o_spans_three        = spans_three_q;
  assign bus.o_needs_second_cycle = spans_two_q;
  assign bus.o_needs_third_cycle  = spans_three_q;
  assign bus.o_can_coalesce       = held_valid_q & ~flush_pending_q & (held_last_q == w_first);
  assign bus.o_idle               = ~held_valid_q & ~flush_pending_q;
endmodule
`default_nettype wire

// File: tb/tb_dla_hld_lsu_word_span_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dla_hld_lsu_word_span_decoder : directed scenarios plus random stream   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dla_hld_lsu_word_span_decoder;
  localparam int AW = 32;
  localparam int WA = 26;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  dla_hld_lsu_word_span_decoder_if #(.ADDR_WIDTH(AW), .WORD_ADDR_WIDTH(WA)) bus_a ();
  dla_hld_lsu_word_span_decoder_if #(.ADDR_WIDTH(AW), .WORD_ADDR_WIDTH(WA)) bus_b ();

  dla_hld_lsu_word_span_decoder #(
    .ADDR_WIDTH(AW), .KER_BYTES(32), .MEM_BYTES(64), .MAX_MEM_WORDS_PER_KER_WORD(2)
  ) dut_a (.clock(clock), .reset(reset), .bus(bus_a));

  dla_hld_lsu_word_span_decoder #(
    .ADDR_WIDTH(AW), .KER_BYTES(128), .MEM_BYTES(64), .MAX_MEM_WORDS_PER_KER_WORD(3)
  ) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain_a();
    bus_a.i_valid = 1'b0; bus_a.i_ready = 1'b1; bus_a.i_flush = 1'b1;
    tick();
    bus_a.i_flush = 1'b0;
    for (int k = 0; k < 8 && bus_a.o_idle !== 1'b1; k++) tick();
    #2;
    n_cmp++; if (bus_a.o_idle !== 1'b1) begin n_bad++; $display("FAIL drain_idle: got %b want 1", bus_a.o_idle); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); #2;
    n_cmp++; if (bus_a.o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus_a.o_valid); end
    n_cmp++; if (bus_a.o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus_a.o_ready); end
    n_cmp++; if (bus_a.o_idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b want 1", bus_a.o_idle); end
    n_cmp++; if (bus_a.o_word_addr !== 26'd0) begin n_bad++; $display("FAIL rst_word_addr: got %h want 0", bus_a.o_word_addr); end
    n_cmp++; if ({bus_a.o_spans_two, bus_a.o_spans_three, bus_a.o_can_coalesce} !== 3'b000) begin
      n_bad++; $display("FAIL rst_flags: got %b want 000", {bus_a.o_spans_two, bus_a.o_spans_three, bus_a.o_can_coalesce}); end
    reset = 1'b0;
    tick(); #2;
    n_cmp++; if ({bus_a.o_valid, bus_a.o_ready, bus_a.o_idle} !== 3'b011) begin
      n_bad++; $display("FAIL post_rst: got %b want 011", {bus_a.o_valid, bus_a.o_ready, bus_a.o_idle}); end
  endtask

  task automatic test_coalesce();
    bus_a.i_ready = 1'b1; bus_a.i_valid = 1'b1; bus_a.i_addr = 32'h000; #2;
    n_cmp++; if (bus_a.o_valid !== 1'b0) begin n_bad++; $display("FAIL coal_first_valid: got %b want 0", bus_a.o_valid); end
    tick(); bus_a.i_addr = 32'h020; #2;
    n_cmp++; if (bus_a.o_valid !== 1'b1) begin n_bad++; $display("FAIL coal_valid: got %b want 1", bus_a.o_valid); end
    n_cmp++; if (bus_a.o_word_addr !== 26'h0) begin n_bad++; $display("FAIL coal_word_addr: got %h want 0", bus_a.o_word_addr); end
    n_cmp++; if (bus_a.o_spans_two !== 1'b0) begin n_bad++; $display("FAIL coal_spans_two: got %b want 0", bus_a.o_spans_two); end
    n_cmp++; if (bus_a.o_can_coalesce !== 1'b1) begin n_bad++; $display("FAIL coal_cc: got %b want 1", bus_a.o_can_coalesce); end
    n_cmp++; if (bus_a.o_ready !== 1'b1) begin n_bad++; $display("FAIL coal_ready: got %b want 1", bus_a.o_ready); end
    tick(); bus_a.i_valid = 1'b0; #2;
    n_cmp++; if ({bus_a.o_valid, bus_a.o_idle} !== 2'b00) begin
      n_bad++; $display("FAIL coal_held: got %b want 00", {bus_a.o_valid, bus_a.o_idle}); end
    drain_a();
  endtask

  task automatic test_two_span();
    bus_a.i_ready = 1'b1; bus_a.i_valid = 1'b1; bus_a.i_addr = 32'h030;
    tick(); bus_a.i_addr = 32'h050; #2;
    n_cmp++; if (bus_a.o_word_addr !== 26'h0) begin n_bad++; $display("FAIL two_word_addr: got %h want 0", bus_a.o_word_addr); end
    n_cmp++; if ({bus_a.o_spans_two, bus_a.o_needs_second_cycle, bus_a.o_spans_three} !== 3'b110) begin
      n_bad++; $display("FAIL two_flags: got %b want 110", {bus_a.o_spans_two, bus_a.o_needs_second_cycle, bus_a.o_spans_three}); end
    n_cmp++; if (bus_a.o_can_coalesce !== 1'b1) begin n_bad++; $display("FAIL two_cc: got %b want 1", bus_a.o_can_coalesce); end
    tick();
    drain_a();
  endtask

  task automatic test_three_span();
    bus_b.i_ready = 1'b1; bus_b.i_valid = 1'b1; bus_b.i_addr = 32'h030;
    tick(); bus_b.i_addr = 32'h200; #2;
    n_cmp++; if (bus_b.o_valid !== 1'b1) begin n_bad++; $display("FAIL three_valid: got %b want 1", bus_b.o_valid); end
    n_cmp++; if (bus_b.o_word_addr !== 26'h0) begin n_bad++; $display("FAIL three_word_addr: got %h want 0", bus_b.o_word_addr); end
    n_cmp++; if ({bus_b.o_spans_two, bus_b.o_spans_three, bus_b.o_needs_third_cycle} !== 3'b111) begin
      n_bad++; $display("FAIL three_flags: got %b want 111", {bus_b.o_spans_two, bus_b.o_spans_three, bus_b.o_needs_third_cycle}); end
    n_cmp++; if (bus_b.o_can_coalesce !== 1'b0) begin n_bad++; $display("FAIL three_cc: got %b want 0", bus_b.o_can_coalesce); end
    tick();
    bus_b.i_valid = 1'b0; bus_b.i_flush = 1'b1;
    tick();
    bus_b.i_flush = 1'b0;
    for (int k = 0; k < 8 && bus_b.o_idle !== 1'b1; k++) tick();
    #2;
    n_cmp++; if (bus_b.o_idle !== 1'b1) begin n_bad++; $display("FAIL three_drain_idle: got %b want 1", bus_b.o_idle); end
  endtask

  task automatic test_flush();
    bus_a.i_ready = 1'b1; bus_a.i_valid = 1'b1; bus_a.i_addr = 32'h040;
    tick();
    bus_a.i_valid = 1'b0; bus_a.i_flush = 1'b1; bus_a.i_ready = 1'b0; #2;
    n_cmp++; if (bus_a.o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_pre_valid: got %b want 0", bus_a.o_valid); end
    tick();
    bus_a.i_flush = 1'b0; #2;
    n_cmp++; if (bus_a.o_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid: got %b want 1", bus_a.o_valid); end
    n_cmp++; if (bus_a.o_word_addr !== 26'h1) begin n_bad++; $display("FAIL flush_word_addr: got %h want 1", bus_a.o_word_addr); end
    n_cmp++; if (bus_a.o_can_coalesce !== 1'b0) begin n_bad++; $display("FAIL flush_cc: got %b want 0", bus_a.o_can_coalesce); end
    n_cmp++; if ({bus_a.o_ready, bus_a.o_idle} !== 2'b00) begin
      n_bad++; $display("FAIL flush_pending_ready: got %b want 00", {bus_a.o_ready, bus_a.o_idle}); end
    tick();
    bus_a.i_ready = 1'b1; #2;
    n_cmp++; if ({bus_a.o_valid, bus_a.o_ready} !== 2'b10) begin
      n_bad++; $display("FAIL flush_fire: got %b want 10", {bus_a.o_valid, bus_a.o_ready}); end
    tick(); #2;
    n_cmp++; if ({bus_a.o_idle, bus_a.o_ready, bus_a.o_valid} !== 3'b110) begin
      n_bad++; $display("FAIL flush_after: got %b want 110", {bus_a.o_idle, bus_a.o_ready, bus_a.o_valid}); end
  endtask

  task automatic test_backpressure();
    bus_a.i_ready = 1'b1; bus_a.i_valid = 1'b1; bus_a.i_addr = 32'h100;
    tick();
    bus_a.i_addr = 32'h140; bus_a.i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      n_cmp++; if ({bus_a.o_valid, bus_a.o_ready} !== 2'b10) begin
        n_bad++; $display("FAIL bp_handshake[%0d]: got %b want 10", c, {bus_a.o_valid, bus_a.o_ready}); end
      n_cmp++; if (bus_a.o_word_addr !== 26'h4) begin
        n_bad++; $display("FAIL bp_word_addr[%0d]: got %h want 4", c, bus_a.o_word_addr); end
      tick();
    end
    bus_a.i_ready = 1'b1; #2;
    n_cmp++; if ({bus_a.o_valid, bus_a.o_ready, bus_a.o_can_coalesce} !== 3'b110) begin
      n_bad++; $display("FAIL bp_release: got %b want 110", {bus_a.o_valid, bus_a.o_ready, bus_a.o_can_coalesce}); end
    tick();
    bus_a.i_valid = 1'b0; #2;
    n_cmp++; if ({bus_a.o_word_addr, bus_a.o_idle} !== {26'h5, 1'b0}) begin
      n_bad++; $display("FAIL bp_accepted: got %h/%b want 5/0", bus_a.o_word_addr, bus_a.o_idle); end
    drain_a();
  endtask

  task automatic test_reset_midstream();
    bus_a.i_ready = 1'b1; bus_a.i_valid = 1'b1; bus_a.i_addr = 32'h080;
    tick();
    bus_a.i_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; #2;
    n_cmp++; if ({bus_a.o_idle, bus_a.o_valid, bus_a.o_ready} !== 3'b101) begin
      n_bad++; $display("FAIL midrst_state: got %b want 101", {bus_a.o_idle, bus_a.o_valid, bus_a.o_ready}); end
    n_cmp++; if (bus_a.o_word_addr !== 26'h0) begin n_bad++; $display("FAIL midrst_word_addr: got %h want 0", bus_a.o_word_addr); end
    bus_a.i_valid = 1'b1; bus_a.i_addr = 32'h0C0; #2;
    n_cmp++; if (bus_a.o_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_fire: got %b want 0", bus_a.o_valid); end
    tick();
    drain_a();
  endtask

  // Reference: every accepted address yields one command in order; the queue head is the held word.
  task automatic test_random();
    logic [31:0] q[$];
    bit          fp = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit iv, ir, fl, held, ev, ef, er;
      logic [31:0] a;
      longint f, l;
      iv = ($urandom_range(0, 9) < 6);
      ir = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 19) == 0);
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF80 | ($urandom & 32'h7F)) : ($urandom & 32'h0000_01F0);
      bus_a.i_valid = iv; bus_a.i_ready = ir; bus_a.i_flush = fl; bus_a.i_addr = a;
      #2;
      held = (q.size() > 0);
      ev   = held && (iv || fp);
      ef   = ev && ir;
      er   = !fp && (!held || ef);
      n_cmp++; if (bus_a.o_valid !== ev) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus_a.o_valid, ev); end
      n_cmp++; if (bus_a.o_ready !== er) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, bus_a.o_ready, er); end
      n_cmp++; if (bus_a.o_idle !== (!held && !fp)) begin
        n_bad++; $display("FAIL rnd_idle@%0d: got %b want %b", cyc, bus_a.o_idle, !held && !fp); end
      if (held) begin
        f = longint'(q[0]) / 64;
        l = ((longint'(q[0]) + 31) % 64'h1_0000_0000) / 64;
        n_cmp++; if (bus_a.o_word_addr !== f[WA-1:0]) begin
          n_bad++; $display("FAIL rnd_word_addr@%0d: got %h want %h", cyc, bus_a.o_word_addr, f[WA-1:0]); end
        n_cmp++; if ({bus_a.o_spans_two, bus_a.o_needs_second_cycle, bus_a.o_spans_three, bus_a.o_needs_third_cycle}
                     !== {(l != f), (l != f), 2'b00}) begin
          n_bad++; $display("FAIL rnd_flags@%0d: got %b want %b", cyc,
            {bus_a.o_spans_two, bus_a.o_needs_second_cycle, bus_a.o_spans_three, bus_a.o_needs_third_cycle},
            {(l != f), (l != f), 2'b00}); end
        if (ev) begin
          n_cmp++; if (bus_a.o_can_coalesce !== (!fp && (l == longint'(a) / 64))) begin
            n_bad++; $display("FAIL rnd_cc@%0d: got %b want %b", cyc, bus_a.o_can_coalesce, !fp && (l == longint'(a) / 64)); end
        end
      end
      tick();
      if (ef) void'(q.pop_front());
      if (iv && er) q.push_back(a);
      if (fp) begin
        if (!held || ef) fp = 1'b0;
      end else if (fl) begin
        fp = 1'b1;
      end
    end
    bus_a.i_flush = 1'b0;
    drain_a();
  endtask

`ifdef DLA_HLD_LSU_SPAN_TIMEOUT_FLUSH_EN
  task automatic test_timeout();
    int n = 0;
    bus_a.i_ready = 1'b1; bus_a.i_valid = 1'b1; bus_a.i_addr = 32'h040;
    tick();
    bus_a.i_valid = 1'b0; #2;
    while (bus_a.o_valid !== 1'b1 && n < 400) begin tick(); #2; n++; end
    n_cmp++; if (n != 255) begin n_bad++; $display("FAIL timeout_latency: got %0d want 255", n); end
    n_cmp++; if ({bus_a.o_can_coalesce, bus_a.o_word_addr} !== {1'b0, 26'h1}) begin
      n_bad++; $display("FAIL timeout_cmd: got %b/%h want 0/1", bus_a.o_can_coalesce, bus_a.o_word_addr); end
    tick(); #2;
    n_cmp++; if (bus_a.o_idle !== 1'b1) begin n_bad++; $display("FAIL timeout_idle: got %b want 1", bus_a.o_idle); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus_a.i_valid = 1'b0; bus_a.i_addr = '0; bus_a.i_flush = 1'b0; bus_a.i_ready = 1'b0;
    bus_b.i_valid = 1'b0; bus_b.i_addr = '0; bus_b.i_flush = 1'b0; bus_b.i_ready = 1'b0;
    test_reset();
    test_coalesce();
    test_two_span();
    test_three_span();
    test_flush();
    test_backpressure();
    test_reset_midstream();
    test_random();
`ifdef DLA_HLD_LSU_SPAN_TIMEOUT_FLUSH_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
